pic_ctrl_seq: RTL and testbench

Parametrised, clocked successor to the 8259 control logic. It decodes the ICW1–ICW4 initialisation sequence and OCW1–OCW3 operation commands from the CPU write port, then runs the two-pulse INTA acknowledge handshake toward the CPU. On the second pulse it delivers the interrupt vector and emits EOI commands, including auto-EOI, to the in-service logic. It sits between the bus/read-write interface and the priority resolver/ISR block, and supports 2–8 request lines.

---
 rtl/pic_ctrl_seq.sv | 214 +++++++++++++++++++++
 tb/tb_pic_ctrl_seq.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_ctrl_seq.sv
// Purpose: 8259-style control sequencer; decodes ICW1-4 and OCW1-3 writes and runs the two-pulse INTA vector handshake.
// Latency: writes visible next cycle; INTA pulses, int/freeze/vector one cycle after the inta_n transition; EOI one cycle after cause.
// Backpressure: none, a write or an inta_n edge is accepted every cycle. Optional auto-EOI is built when PIC_CTRL_AEOI_EN is defined.
module pic_ctrl_seq #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = $clog2(N_IRQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic             a0,
    input  logic [7:0]       din,
    input  logic             intreq,
    input  logic [ID_W-1:0]  irq_id,
    input  logic             inta_n,
    output logic             int_o,
    output logic             pulse1_o,
    output logic             pulse2_o,
    output logic             freeze_o,
    output logic [7:0]       vector_o,
    output logic             vector_vld,
    output logic [N_IRQ-1:0] mask_o,
    output logic             aeoi_o,
    output logic [1:0]       rr_ris_o,
    output logic             eoi_o,
    output logic             eoi_spec_o,
    output logic [ID_W-1:0]  eoi_lvl_o,
    output logic             init_done
);

    typedef enum logic [2:0] {IDLE, W_ICW2, W_ICW3, W_ICW4, READY} init_state_t;
    typedef enum logic [2:0] {I_IDLE, I_REQ, I_P1, I_WAIT2, I_P2} inta_state_t;

    init_state_t     init_q, init_nxt;
    inta_state_t     inta_q, inta_nxt;

    logic            sngl_q;
    logic            ic4_q;
    logic [7-ID_W:0] base_q;
    logic [7:0]      cascade_q;
    logic [ID_W-1:0] id_q;
    logic            inta_prev;
    logic            aeoi_pend;

    logic            icw1;
    logic            ready_wr;
    logic            ocw2_ns;
    logic            ocw2_sp;
    logic            inta_fall;
    logic            inta_rise;
    logic            go_p1;
    logic            go_p2;
    logic            aeoi_trig;

    // The cascade word is stored for completeness only; nothing downstream consumes it.
    logic            unused_bits;
    assign unused_bits = ^cascade_q;

    // ICW1 is recognised in every state and overrides everything else on its cycle.
    assign icw1      = wr && !a0 && din[4];
    assign ready_wr  = wr && !icw1 && (init_q == READY);
    assign ocw2_ns   = ready_wr && !a0 && (din[4:3] == 2'b00) && (din[7:5] == 3'b001);
    assign ocw2_sp   = ready_wr && !a0 && (din[4:3] == 2'b00) && (din[7:5] == 3'b011);
    assign inta_fall = inta_prev && !inta_n;
    assign inta_rise = !inta_prev && inta_n;

    assign init_done  = (init_q == READY);
    assign int_o      = (inta_q == I_REQ);
    assign freeze_o   = (inta_q == I_P1) || (inta_q == I_WAIT2) || (inta_q == I_P2);
    assign vector_vld = (inta_q == I_P2);
    assign vector_o   = vector_vld ? {base_q, id_q} : 8'h00;

    // Init sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) init_q <= IDLE;
        else       init_q <= init_nxt;
    end

    // Init next state: skip ICW3 in single mode and ICW4 when ICW1 did not ask for it.
    always_comb begin
        init_nxt = init_q;
        if (icw1) begin
            init_nxt = W_ICW2;
        end else if (wr) begin
            case (init_q)
                W_ICW2:  init_nxt = !sngl_q ? W_ICW3 : (ic4_q ? W_ICW4 : READY);
                W_ICW3:  init_nxt = ic4_q ? W_ICW4 : READY;
                W_ICW4:  init_nxt = READY;
                default: init_nxt = init_q;
            endcase
        end
    end

    // ICW/OCW register file; writes during W_ICWx are consumed as that ICW whatever a0 says.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sngl_q    <= 1'b0;
            ic4_q     <= 1'b0;
            base_q    <= '0;
            cascade_q <= 8'h00;
            mask_o    <= '0;
            rr_ris_o  <= 2'b00;
        end else if (icw1) begin
            sngl_q   <= din[1];
            ic4_q    <= din[0];
            mask_o   <= '0;
            rr_ris_o <= 2'b00;
        end else if (wr) begin
            case (init_q)
                W_ICW2: base_q    <= din[7:ID_W];
                W_ICW3: cascade_q <= din;
                READY: begin
                    if (a0)                        mask_o   <= din[N_IRQ-1:0];
                    else if (din[4:3] == 2'b01)    rr_ris_o <= din[1:0];
                end
                default: ;
            endcase
        end
    end

`ifdef PIC_CTRL_AEOI_EN
    logic aeoi_q;

    // Auto-EOI mode bit from ICW4, cleared by every ICW1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                           aeoi_q <= 1'b0;
        else if (icw1)                       aeoi_q <= 1'b0;
        else if (wr && (init_q == W_ICW4))   aeoi_q <= din[1];
    end

    assign aeoi_o = aeoi_q;
`else
    assign aeoi_o = 1'b0;
`endif

    // INTA handshake state, previous inta_n sample, captured id and acknowledge pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inta_q    <= I_IDLE;
            inta_prev <= 1'b1;
            id_q      <= '0;
            pulse1_o  <= 1'b0;
            pulse2_o  <= 1'b0;
        end else begin
            inta_q    <= inta_nxt;
            inta_prev <= inta_n;
            pulse1_o  <= go_p1;
            pulse2_o  <= go_p2;
            if (go_p1) id_q <= intreq ? irq_id : ID_W'(N_IRQ - 1);
        end
    end

    // INTA next state: ICW1 aborts, an edge in I_REQ beats a withdrawn request.
    always_comb begin
        inta_nxt  = inta_q;
        go_p1     = 1'b0;
        go_p2     = 1'b0;
        aeoi_trig = 1'b0;
        if (icw1) begin
            inta_nxt = I_IDLE;
        end else begin
            case (inta_q)
                I_IDLE:  if (intreq && init_done) inta_nxt = I_REQ;
                I_REQ: begin
                    if (inta_fall) begin
                        inta_nxt = I_P1;
                        go_p1    = 1'b1;
                    end else if (!intreq) begin
                        inta_nxt = I_IDLE;
                    end
                end
                I_P1:    if (inta_rise) inta_nxt = I_WAIT2;
                I_WAIT2: begin
                    if (inta_fall) begin
                        inta_nxt = I_P2;
                        go_p2    = 1'b1;
                    end
                end
                I_P2: begin
                    if (inta_rise) begin
                        inta_nxt  = I_IDLE;
                        aeoi_trig = aeoi_o;
                    end
                end
                default: inta_nxt = I_IDLE;
            endcase
        end
    end

    // EOI strobe: OCW2 takes the slot, a colliding auto-EOI is deferred by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eoi_o      <= 1'b0;
            eoi_spec_o <= 1'b0;
            eoi_lvl_o  <= '0;
            aeoi_pend  <= 1'b0;
        end else if (ocw2_ns || ocw2_sp) begin
            eoi_o      <= 1'b1;
            eoi_spec_o <= ocw2_sp;
            eoi_lvl_o  <= ocw2_sp ? din[ID_W-1:0] : '0;
            if (aeoi_trig) aeoi_pend <= 1'b1;
        end else if (aeoi_trig || aeoi_pend) begin
            eoi_o      <= 1'b1;
            eoi_spec_o <= 1'b0;
            eoi_lvl_o  <= '0;
            aeoi_pend  <= 1'b0;
        end else begin
            eoi_o      <= 1'b0;
            eoi_spec_o <= 1'b0;
            eoi_lvl_o  <= '0;
        end
    end

endmodule

// File: tb/tb_pic_ctrl_seq.sv
// Bench for pic_ctrl_seq: an 8-line and a 4-line instance share the bus and INTA stimulus.
// Expected values come from a command-level model of the init sequence and register contents.
// Expectations follow PIC_CTRL_AEOI_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_pic_ctrl_seq;
`ifdef PIC_CTRL_AEOI_EN
    localparam bit AEOI_EN = 1'b1;
`else
    localparam bit AEOI_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr = 1'b0;
    logic       a0 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       intreq = 1'b0;
    logic       inta_n = 1'b1;
    logic [2:0] irq_id8 = 3'd0;
    logic [1:0] irq_id4 = 2'd0;

    // bit 0 = 8-line instance, bit 1 = 4-line instance
    logic [1:0] int_w, p1_w, p2_w, frz_w, vld_w, aeoi_w, eoi_w, spec_w, init_w;
    logic [7:0] vec8, vec4, mask8;
    logic [3:0] mask4;
    logic [1:0] rr8, rr4, lvl4;
    logic [2:0] lvl8;

    int n_checks = 0;
    int n_fail = 0;

    // Model: remaining ICW numbers, and register contents implied by the writes so far.
    int         m_todo[$];
    logic [7:0] m_icw2, m_mask;
    logic [1:0] m_rr;
    logic       m_aeoi, m_init;

    always #5 clk = ~clk;

    pic_ctrl_seq #(.N_IRQ(8)) u_dut8 (
        .clk(clk), .reset(reset), .wr(wr), .a0(a0), .din(din), .intreq(intreq),
        .irq_id(irq_id8), .inta_n(inta_n), .int_o(int_w[0]), .pulse1_o(p1_w[0]),
        .pulse2_o(p2_w[0]), .freeze_o(frz_w[0]), .vector_o(vec8), .vector_vld(vld_w[0]),
        .mask_o(mask8), .aeoi_o(aeoi_w[0]), .rr_ris_o(rr8), .eoi_o(eoi_w[0]),
        .eoi_spec_o(spec_w[0]), .eoi_lvl_o(lvl8), .init_done(init_w[0])
    );

    pic_ctrl_seq #(.N_IRQ(4)) u_dut4 (
        .clk(clk), .reset(reset), .wr(wr), .a0(a0), .din(din), .intreq(intreq),
        .irq_id(irq_id4), .inta_n(inta_n), .int_o(int_w[1]), .pulse1_o(p1_w[1]),
        .pulse2_o(p2_w[1]), .freeze_o(frz_w[1]), .vector_o(vec4), .vector_vld(vld_w[1]),
        .mask_o(mask4), .aeoi_o(aeoi_w[1]), .rr_ris_o(rr4), .eoi_o(eoi_w[1]),
        .eoi_spec_o(spec_w[1]), .eoi_lvl_o(lvl4), .init_done(init_w[1])
    );

    function automatic logic [7:0] exp_vec(input int idw, input logic [7:0] icw2, input int id);
        logic [7:0] hi_mask;
        hi_mask = 8'hFF << idw;
        return (icw2 & hi_mask) | 8'(id & ((1 << idw) - 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_todo.delete();
        m_icw2 = 8'h00; m_mask = 8'h00; m_rr = 2'b00; m_aeoi = 1'b0; m_init = 1'b0;
    endtask

    task automatic bus_write(input logic a, input logic [7:0] d);
        wr = 1'b1; a0 = a; din = d;
        tick();
        wr = 1'b0; a0 = 1'b0; din = 8'h00;
        if (!a && d[4]) begin
            m_todo.delete();
            m_todo.push_back(2);
            if (!d[1]) m_todo.push_back(3);
            if (d[0])  m_todo.push_back(4);
            m_mask = 8'h00; m_rr = 2'b00; m_aeoi = 1'b0; m_init = 1'b0;
        end else if (m_todo.size() != 0) begin
            if (m_todo[0] == 2) m_icw2 = d;
            if (m_todo[0] == 4) m_aeoi = AEOI_EN && d[1];
            void'(m_todo.pop_front());
            if (m_todo.size() == 0) m_init = 1'b1;
        end else if (m_init) begin
            if (a)                      m_mask = d;
            else if (d[4:3] == 2'b01)   m_rr = d[1:0];
        end
    endtask

    task automatic std_init(input logic [7:0] icw2);
        bus_write(1'b0, 8'h13);
        bus_write(1'b1, icw2);
        bus_write(1'b1, 8'h03);
    endtask

    // One full acknowledge cycle; spur withdraws intreq on the first falling edge,
    // collide writes a specific OCW2 on the same edge as the final rise.
    task automatic run_inta(input int id, input bit spur, input bit collide, input int gap);
        int e8, e4;
        e8 = spur ? 7 : id;
        e4 = spur ? 3 : (id % 4);
        intreq = 1'b1; irq_id8 = 3'(id); irq_id4 = 2'(id);
        tick();
        n_checks++;
        if (int_w !== 2'b11 || p1_w !== 2'b00 || frz_w !== 2'b00) begin
            n_fail++; $display("FAIL inta_req int=%b p1=%b frz=%b want int=11 p1=00 frz=00", int_w, p1_w, frz_w);
        end
        repeat (gap) tick();
        inta_n = 1'b0;
        if (spur) intreq = 1'b0;
        tick();
        n_checks++;
        if (p1_w !== 2'b11 || int_w !== 2'b00 || frz_w !== 2'b11 || p2_w !== 2'b00) begin
            n_fail++; $display("FAIL inta_pulse1 p1=%b int=%b frz=%b p2=%b want 11 00 11 00", p1_w, int_w, frz_w, p2_w);
        end
        intreq = 1'b0;
        tick();
        n_checks++;
        if (p1_w !== 2'b00 || frz_w !== 2'b11) begin
            n_fail++; $display("FAIL inta_p1_width p1=%b frz=%b want p1=00 frz=11", p1_w, frz_w);
        end
        inta_n = 1'b1;
        tick();
        repeat (gap) tick();
        n_checks++;
        if (frz_w !== 2'b11 || vld_w !== 2'b00 || p2_w !== 2'b00) begin
            n_fail++; $display("FAIL inta_wait2 frz=%b vld=%b p2=%b want 11 00 00", frz_w, vld_w, p2_w);
        end
        inta_n = 1'b0;
        tick();
        n_checks++;
        if (p2_w !== 2'b11 || vld_w !== 2'b11 || vec8 !== exp_vec(3, m_icw2, e8) || vec4 !== exp_vec(2, m_icw2, e4)) begin
            n_fail++; $display("FAIL inta_vector p2=%b vld=%b vec8=%h vec4=%h want 11 11 %h %h",
                               p2_w, vld_w, vec8, vec4, exp_vec(3, m_icw2, e8), exp_vec(2, m_icw2, e4));
        end
        tick();
        n_checks++;
        if (p2_w !== 2'b00 || vld_w !== 2'b11 || vec8 !== exp_vec(3, m_icw2, e8)) begin
            n_fail++; $display("FAIL inta_vec_hold p2=%b vld=%b vec8=%h want 00 11 %h", p2_w, vld_w, vec8, exp_vec(3, m_icw2, e8));
        end
        inta_n = 1'b1;
        if (collide) bus_write(1'b0, 8'h63);
        else         tick();
        n_checks++;
        if (vld_w !== 2'b00 || frz_w !== 2'b00) begin
            n_fail++; $display("FAIL inta_end vld=%b frz=%b want 00 00", vld_w, frz_w);
        end
        n_checks++;
        if (collide) begin
            if (eoi_w !== 2'b11 || spec_w !== 2'b11 || lvl8 !== 3'd3 || lvl4 !== 2'd3) begin
                n_fail++; $display("FAIL eoi_collide_ocw2 eoi=%b spec=%b lvl8=%0d lvl4=%0d want 11 11 3 3", eoi_w, spec_w, lvl8, lvl4);
            end
        end else if (eoi_w !== {2{m_aeoi}} || spec_w !== 2'b00) begin
            n_fail++; $display("FAIL aeoi_strobe eoi=%b spec=%b want %b 00", eoi_w, spec_w, {2{m_aeoi}});
        end
        tick();
        n_checks++;
        if (eoi_w !== (collide ? {2{m_aeoi}} : 2'b00) || spec_w !== 2'b00) begin
            n_fail++; $display("FAIL eoi_followup eoi=%b spec=%b want %b 00", eoi_w, spec_w, collide ? {2{m_aeoi}} : 2'b00);
        end
        tick();
        n_checks++;
        if (eoi_w !== 2'b00 || int_w !== 2'b00) begin
            n_fail++; $display("FAIL inta_idle eoi=%b int=%b want 00 00", eoi_w, int_w);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) tick();
        n_checks++;
        if ({int_w, p1_w, p2_w, frz_w, vld_w, aeoi_w, eoi_w, spec_w, init_w, vec8, vec4, mask8, mask4, rr8, rr4, lvl8, lvl4} !== '0) begin
            n_fail++; $display("FAIL reset_outputs int=%b frz=%b init=%b mask8=%h vec8=%h want all zero", int_w, frz_w, init_w, mask8, vec8);
        end
        reset = 1'b0;
        intreq = 1'b1;
        tick();
        tick();
        n_checks++;
        if (init_w !== 2'b00 || int_w !== 2'b00) begin
            n_fail++; $display("FAIL reset_no_init init=%b int=%b want 00 00", init_w, int_w);
        end
        intreq = 1'b0;
    endtask

    task automatic test_init();
        bus_write(1'b0, 8'h13);
        bus_write(1'b1, 8'h40);
        n_checks++;
        if (init_w !== 2'b00) begin
            n_fail++; $display("FAIL init_wait_icw4 init=%b want 00", init_w);
        end
        bus_write(1'b1, 8'h03);
        n_checks++;
        if (init_w !== 2'b11 || aeoi_w !== {2{AEOI_EN}} || init_w !== {2{m_init}}) begin
            n_fail++; $display("FAIL init_done init=%b aeoi=%b want 11 %b", init_w, aeoi_w, {2{AEOI_EN}});
        end
    endtask

    task automatic test_ocw();
        logic a;
        logic [7:0] d;
        logic exp_eoi, exp_spec;
        bus_write(1'b1, 8'hA5);
        n_checks++;
        if (mask8 !== 8'hA5 || mask4 !== 4'h5) begin
            n_fail++; $display("FAIL ocw1_mask mask8=%h mask4=%h want a5 5", mask8, mask4);
        end
        bus_write(1'b0, 8'h63);
        n_checks++;
        if (eoi_w !== 2'b11 || spec_w !== 2'b11 || lvl8 !== 3'd3 || lvl4 !== 2'd3) begin
            n_fail++; $display("FAIL ocw2_specific eoi=%b spec=%b lvl8=%0d lvl4=%0d want 11 11 3 3", eoi_w, spec_w, lvl8, lvl4);
        end
        tick();
        n_checks++;
        if (eoi_w !== 2'b00) begin
            n_fail++; $display("FAIL ocw2_one_cycle eoi=%b want 00", eoi_w);
        end
        bus_write(1'b0, 8'h0B);
        n_checks++;
        if (rr8 !== 2'd3 || rr4 !== 2'd3) begin
            n_fail++; $display("FAIL ocw3_rr rr8=%0d rr4=%0d want 3 3", rr8, rr4);
        end
        for (int k = 0; k < 14; k++) begin
            a = 1'($urandom);
            d = 8'($urandom);
            if (!a) d[4] = 1'b0;
            bus_write(a, d);
            exp_eoi  = !a && (d[4:3] == 2'b00) && (d[7:5] == 3'b001 || d[7:5] == 3'b011);
            exp_spec = exp_eoi && (d[7:5] == 3'b011);
            n_checks++;
            if (mask8 !== m_mask || mask4 !== m_mask[3:0] || rr8 !== m_rr || rr4 !== m_rr ||
                eoi_w !== {2{exp_eoi}} || spec_w !== {2{exp_spec}} ||
                (exp_spec && (lvl8 !== d[2:0] || lvl4 !== d[1:0]))) begin
                n_fail++; $display("FAIL ocw_random a0=%b din=%h mask8=%h rr8=%0d eoi=%b spec=%b lvl8=%0d want mask=%h rr=%0d eoi=%b spec=%b",
                                   a, d, mask8, rr8, eoi_w, spec_w, lvl8, m_mask, m_rr, {2{exp_eoi}}, {2{exp_spec}});
            end
        end
    endtask

    task automatic test_inta();
        run_inta(5, 1'b0, 1'b0, 0);
        n_checks++;
        if (m_icw2 !== 8'h40 || exp_vec(3, m_icw2, 5) !== 8'h45) begin
            n_fail++; $display("FAIL model_base icw2=%h want 40", m_icw2);
        end
        for (int k = 0; k < 6; k++)
            run_inta(int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    endtask

    task automatic test_spurious();
        run_inta(5, 1'b1, 1'b0, 1);
    endtask

    task automatic test_withdraw();
        intreq = 1'b1;
        tick();
        intreq = 1'b0;
        tick();
        n_checks++;
        if (int_w !== 2'b00) begin
            n_fail++; $display("FAIL withdraw_int int=%b want 00", int_w);
        end
        inta_n = 1'b0;
        tick();
        n_checks++;
        if (p1_w !== 2'b00 || frz_w !== 2'b00) begin
            n_fail++; $display("FAIL idle_edge_ignored p1=%b frz=%b want 00 00", p1_w, frz_w);
        end
        inta_n = 1'b1;
        tick();
    endtask

    task automatic test_abort();
        intreq = 1'b1;
        tick();
        inta_n = 1'b0;
        tick();
        intreq = 1'b0;
        inta_n = 1'b1;
        tick();
        bus_write(1'b0, 8'h13);
        n_checks++;
        if (frz_w !== 2'b00 || init_w !== 2'b00 || int_w !== 2'b00) begin
            n_fail++; $display("FAIL abort_state frz=%b init=%b int=%b want 00 00 00", frz_w, init_w, int_w);
        end
        inta_n = 1'b0;
        tick();
        n_checks++;
        if (p2_w !== 2'b00 || vld_w !== 2'b00) begin
            n_fail++; $display("FAIL abort_no_pulse2 p2=%b vld=%b want 00 00", p2_w, vld_w);
        end
        inta_n = 1'b1;
        tick();
        bus_write(1'b1, 8'h40);
        bus_write(1'b1, 8'h03);
        intreq = 1'b1;
        tick();
        inta_n = 1'b0;
        bus_write(1'b0, 8'h13);
        n_checks++;
        if (p1_w !== 2'b00 || frz_w !== 2'b00 || int_w !== 2'b00) begin
            n_fail++; $display("FAIL icw1_beats_edge p1=%b frz=%b int=%b want 00 00 00", p1_w, frz_w, int_w);
        end
        intreq = 1'b0;
        inta_n = 1'b1;
        tick();
    endtask

    task automatic test_init_variants();
        logic       aa;
        logic [7:0] d;
        for (int k = 0; k < 6; k++) begin
            d = {3'b000, 1'b1, 2'b00, 2'($urandom)};
            bus_write(1'b0, d);
            n_checks++;
            if (mask8 !== 8'h00 || rr8 !== 2'b00 || aeoi_w !== 2'b00 || init_w !== 2'b00) begin
                n_fail++; $display("FAIL icw1_clears mask8=%h rr8=%0d aeoi=%b init=%b want 00 0 00 00", mask8, rr8, aeoi_w, init_w);
            end
            for (int w = 0; w < 3 && !m_init; w++) begin
                aa = 1'($urandom);
                d = 8'($urandom);
                if (!aa) d[4] = 1'b0;
                bus_write(aa, d);
                n_checks++;
                if (init_w !== {2{m_init}} || aeoi_w !== {2{m_aeoi}}) begin
                    n_fail++; $display("FAIL icw_sequence step=%0d init=%b aeoi=%b want %b %b", w, init_w, aeoi_w, {2{m_init}}, {2{m_aeoi}});
                end
            end
        end
    endtask

    task automatic test_reduced();
        std_init(8'hF8);
        n_checks++;
        if (aeoi_w !== {2{AEOI_EN}} || init_w !== 2'b11) begin
            n_fail++; $display("FAIL reduced_init aeoi=%b init=%b want %b 11", aeoi_w, init_w, {2{AEOI_EN}});
        end
        run_inta(2, 1'b0, 1'b0, 0);
    endtask

    task automatic test_async_reset();
        intreq = 1'b1;
        tick();
        inta_n = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({int_w, p1_w, frz_w, vld_w, init_w, mask8, mask4, vec8} !== '0) begin
            n_fail++; $display("FAIL async_reset frz=%b p1=%b init=%b mask8=%h want all zero", frz_w, p1_w, init_w, mask8);
        end
        intreq = 1'b0;
        inta_n = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (init_w !== 2'b00 || frz_w !== 2'b00) begin
            n_fail++; $display("FAIL post_reset init=%b frz=%b want 00 00", init_w, frz_w);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_ocw();
        test_inta();
        test_spurious();
        test_withdraw();
        test_abort();
        test_init_variants();
        test_reduced();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
